// File: rtl/bcd_entry_ctrl.sv
// Operator entry sequencer for a signed 3-digit BCD temperature reading:
// debounced key, ones -> tens -> hundreds, commit into current/saved registers.
module bcd_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bcd_input,
  input  logic [3:0] bcd_num,
  input  logic       sign_on,
  output logic [2:0] bcd_press,
  output logic [3:0] curr_ones_value,
  output logic [3:0] curr_tens_value,
  output logic [3:0] curr_huns_value,
  output logic [3:0] save_temp_ones_value,
  output logic [3:0] save_temp_tens_value,
  output logic [3:0] save_temp_huns_value,
  output logic       curr_sign_mode,
  output logic       temp_sign_mode,
  output logic       got_value,
  output logic [2:0] diff_read,
  output logic       digit_err,
  output logic       timeout
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  // state | meaning: S_ONES ones pending, S_TENS tens pending,
  // S_HUNS hundreds+sign pending, S_COMMIT one-cycle register transfer
  typedef enum logic [1:0] {
    S_ONES   = 2'd0,
    S_TENS   = 2'd1,
    S_HUNS   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_deb_cnt;
  logic          r_deb_lock;
  logic [TW-1:0] r_idle_cnt;
  logic [3:0]    r_entry_ones, r_entry_tens, r_entry_huns;
  logic          r_entry_sign;
  logic [3:0]    r_curr_ones, r_curr_tens, r_curr_huns;
  logic [3:0]    r_save_ones, r_save_tens, r_save_huns;
  logic          r_curr_sign, r_save_sign;
  logic [2:0]    r_diff_read;
  logic          r_got_value, r_digit_err, r_timeout;

  logic w_accept, w_digit_ok;
  logic w_ld_ones, w_ld_tens, w_ld_huns, w_commit, w_err, w_expire, w_idle_run;

  // Lock holds off further accepts until the key is released.
  assign w_accept   = bcd_input && !r_deb_lock && (r_deb_cnt == DEB_LAST);
  assign w_digit_ok = (bcd_num <= 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb_cnt  <= '0;
      r_deb_lock <= 1'b0;
    end else if (!bcd_input) begin
      r_deb_cnt  <= '0;
      r_deb_lock <= 1'b0;
    end else begin
      if (w_accept) r_deb_lock <= 1'b1;
      if (r_deb_cnt != DEB_LAST) r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_ONES;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_ones   = 1'b0;
    w_ld_tens   = 1'b0;
    w_ld_huns   = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    w_expire    = 1'b0;
    w_idle_run  = 1'b0;
    case (r_state)
      S_ONES: begin
        if (w_accept) begin
          if (w_digit_ok) begin
            w_ld_ones   = 1'b1;
            w_state_nxt = S_TENS;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_TENS, S_HUNS: begin
        if (w_accept) begin
          if (!w_digit_ok) begin
            w_err = 1'b1;
          end else if (r_state == S_TENS) begin
            w_ld_tens   = 1'b1;
            w_state_nxt = S_HUNS;
          end else begin
            w_ld_huns   = 1'b1;
            w_state_nxt = S_COMMIT;
          end
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_expire    = 1'b1;
          w_state_nxt = S_ONES;
        end else begin
          w_idle_run = 1'b1;
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_ONES;
      end
      default: w_state_nxt = S_ONES;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_idle_cnt <= '0;
    else if (w_idle_run) r_idle_cnt <= r_idle_cnt + 1'b1;
    else r_idle_cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || 1'b0) begin
      r_entry_ones <= '0;
      r_entry_tens <= '0;
      r_entry_huns <= '0;
      r_entry_sign <= 1'b0;
    end else if (w_expire || w_commit) begin
      r_entry_ones <= '0;
      r_entry_tens <= '0;
      r_entry_huns <= '0;
      r_entry_sign <= 1'b0;
    end else begin
      if (w_ld_ones) r_entry_ones <= bcd_num;
      if (w_ld_tens) r_entry_tens <= bcd_num;
      if (w_ld_huns) begin
        r_entry_huns <= bcd_num;
        r_entry_sign <= sign_on;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_curr_ones <= '0;
      r_curr_tens <= '0;
      r_curr_huns <= '0;
      r_curr_sign <= 1'b0;
      r_save_ones <= '0;
      r_save_tens <= '0;
      r_save_huns <= '0;
      r_save_sign <= 1'b0;
      r_diff_read <= '0;
      r_got_value <= 1'b0;
      r_digit_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_got_value <= w_commit;
      r_digit_err <= w_err;
      r_timeout   <= w_expire;
      if (w_commit) begin
        r_save_ones <= r_curr_ones;
        r_save_tens <= r_curr_tens;
        r_save_huns <= r_curr_huns;
        r_save_sign <= r_curr_sign;
        r_curr_ones <= r_entry_ones;
        r_curr_tens <= r_entry_tens;
        r_curr_huns <= r_entry_huns;
        r_curr_sign <= r_entry_sign;
        if (r_diff_read != 3'd7) r_diff_read <= r_diff_read + 3'd1;
      end
    end
  end

  assign bcd_press            = {1'b0, r_state};
  assign curr_ones_value      = r_curr_ones;
  assign curr_tens_value      = r_curr_tens;
  assign curr_huns_value      = r_curr_huns;
  assign save_temp_ones_value = r_save_ones;
  assign save_temp_tens_value = r_save_tens;
  assign save_temp_huns_value = r_save_huns;
  assign curr_sign_mode       = r_curr_sign;
  assign temp_sign_mode       = r_save_sign;
  assign got_value            = r_got_value;
  assign diff_read            = r_diff_read;
  assign digit_err            = r_digit_err;
  assign timeout              = r_timeout;

endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// Scoreboard bench for bcd_entry_ctrl: stimulus pushes expected events,
// a negedge monitor pops and compares on got_value / digit_err / timeout.
module tb_bcd_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       bcd_input;
  logic [3:0] bcd_num;
  logic       sign_on;
  logic [2:0] bcd_press;
  logic [3:0] curr_ones_value, curr_tens_value, curr_huns_value;
  logic [3:0] save_temp_ones_value, save_temp_tens_value, save_temp_huns_value;
  logic       curr_sign_mode, temp_sign_mode, got_value, digit_err, timeout;
  logic [2:0] diff_read;

  always #5 clk = ~clk;

  bcd_entry_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .bcd_input(bcd_input), .bcd_num(bcd_num), .sign_on(sign_on),
    .bcd_press(bcd_press),
    .curr_ones_value(curr_ones_value), .curr_tens_value(curr_tens_value),
    .curr_huns_value(curr_huns_value),
    .save_temp_ones_value(save_temp_ones_value), .save_temp_tens_value(save_temp_tens_value),
    .save_temp_huns_value(save_temp_huns_value),
    .curr_sign_mode(curr_sign_mode), .temp_sign_mode(temp_sign_mode),
    .got_value(got_value), .diff_read(diff_read), .digit_err(digit_err), .timeout(timeout)
  );

  localparam logic [2:0] K_COMMIT = 3'b100;
  localparam logic [2:0] K_ERR    = 3'b010;
  localparam logic [2:0] K_TO     = 3'b001;

  typedef struct packed {
    logic [2:0]  kind;
    logic [2:0]  press;
    logic [11:0] curr;
    logic [11:0] save;
    logic        cs;
    logic        ts;
    logic [2:0]  diff;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_obs, mon_exp, push_ev_v;
  int n_vec = 0;
  int n_err = 0;

  logic [11:0] m_curr, m_save;
  logic        m_cs, m_ts;
  logic [2:0]  m_diff;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic push_ev(input logic [2:0] kind, input logic [2:0] press);
    push_ev_v.kind  = kind;
    push_ev_v.press = press;
    push_ev_v.curr  = m_curr;
    push_ev_v.save  = m_save;
    push_ev_v.cs    = m_cs;
    push_ev_v.ts    = m_ts;
    push_ev_v.diff  = m_diff;
    exp_q.push_back(push_ev_v);
  endtask

  task automatic push_commit(input logic [3:0] o, input logic [3:0] t, input logic [3:0] h,
                             input logic s);
    m_save = m_curr;
    m_ts   = m_cs;
    m_curr = {h, t, o};
    m_cs   = s;
    if (m_diff != 3'd7) m_diff = m_diff + 3'd1;
    push_ev(K_COMMIT, 3'd0);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; accept lands 3 cycles later, new state visible 4 negedges on.
  task automatic press(input logic [3:0] d, input logic s, input int hold,
                       input logic [2:0] exp_press, input string nm);
    bcd_num   = d;
    sign_on   = s;
    bcd_input = 1'b1;
    repeat (4) @(negedge clk);
    check(nm, 32'(bcd_press), 32'(exp_press));
    repeat (hold - 4) @(negedge clk);
    bcd_input = 1'b0;
  endtask

  task automatic enter(input logic [3:0] o, input logic [3:0] t, input logic [3:0] h,
                       input logic s, input string nm);
    press(o, s, 6, 3'd1, {nm, "_ones"});
    gap(4);
    press(t, s, 6, 3'd2, {nm, "_tens"});
    gap(4);
    push_commit(o, t, h, s);
    press(h, s, 6, 3'd3, {nm, "_huns"});
    gap(4);
    check({nm, "_idle_press"}, 32'(bcd_press), 32'd0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_press"}, 32'(bcd_press), 32'd0);
    check({nm, "_curr"}, 32'({curr_huns_value, curr_tens_value, curr_ones_value}), 32'd0);
    check({nm, "_save"},
          32'({save_temp_huns_value, save_temp_tens_value, save_temp_ones_value}), 32'd0);
    check({nm, "_misc"},
          32'({curr_sign_mode, temp_sign_mode, got_value, digit_err, timeout, diff_read}),
          32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && (got_value || digit_err || timeout)) begin
      mon_obs.kind  = {got_value, digit_err, timeout};
      mon_obs.press = bcd_press;
      mon_obs.curr  = {curr_huns_value, curr_tens_value, curr_ones_value};
      mon_obs.save  = {save_temp_huns_value, save_temp_tens_value, save_temp_ones_value};
      mon_obs.cs    = curr_sign_mode;
      mon_obs.ts    = temp_sign_mode;
      mon_obs.diff  = diff_read;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got %h expected none", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          n_err++;
          $display("FAIL event_kind%b: got %h expected %h", mon_exp.kind, mon_obs, mon_exp);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    bcd_input = 1'b0;
    bcd_num   = 4'd0;
    sign_on   = 1'b0;
    m_curr = '0; m_save = '0; m_cs = 1'b0; m_ts = 1'b0; m_diff = '0;
    gap(3);
    check_all_zero("reset");
    rst = 1'b0;
    gap(2);

    enter(4'd5, 4'd2, 4'd1, 1'b0, "basic");
    enter(4'd7, 4'd0, 4'd0, 1'b1, "second");

    // 3-sample glitch must not register
    bcd_num   = 4'd3;
    bcd_input = 1'b1;
    gap(3);
    bcd_input = 1'b0;
    gap(3);
    check("glitch_press", 32'(bcd_press), 32'd0);
    // Long hold: one accept, then the idle timer aborts while the key is still down
    push_ev(K_TO, 3'd0);
    press(4'd3, 1'b0, 200, 3'd1, "hold_accept");
    check("hold_after_timeout", 32'(bcd_press), 32'd0);
    gap(4);

    press(4'd6, 1'b0, 6, 3'd1, "inv_ones");
    gap(4);
    push_ev(K_ERR, 3'd1);
    press(4'hC, 1'b0, 6, 3'd1, "inv_stay");
    gap(4);
    press(4'd8, 1'b0, 6, 3'd2, "inv_tens8");
    gap(4);
    push_commit(4'd6, 4'd8, 4'd0, 1'b0);
    press(4'd0, 1'b0, 6, 3'd3, "inv_commit");
    gap(4);

    // Idle expiry: ones accept in cycle A, expiry at end of A+50
    press(4'd4, 1'b0, 6, 3'd1, "to_ones");
    push_ev(K_TO, 3'd0);
    gap(47);
    check("to_not_early", 32'(bcd_press), 32'd1);
    gap(1);
    check("to_expired", 32'(bcd_press), 32'd0);
    gap(4);

    // Accept lands on the last idle cycle: accept wins
    press(4'd4, 1'b0, 6, 3'd1, "tob_ones");
    gap(44);
    press(4'd9, 1'b0, 6, 3'd2, "to_edge_accept");
    gap(4);
    push_commit(4'd4, 4'd9, 4'd1, 1'b1);
    press(4'd1, 1'b1, 6, 3'd3, "tob_commit");
    gap(4);

    // Asynchronous reset in S_HUNS, between clock edges
    press(4'd1, 1'b0, 6, 3'd1, "rst_ones");
    gap(4);
    press(4'd2, 1'b0, 6, 3'd2, "rst_tens");
    gap(3);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    exp_q.delete();
    m_curr = '0; m_save = '0; m_cs = 1'b0; m_ts = 1'b0; m_diff = '0;
    gap(2);
    rst = 1'b0;
    gap(2);
    enter(4'd3, 4'd2, 4'd1, 1'b0, "post_rst");

    gap(5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
